// File: rtl/regfile_pkg.sv
// Shared widths and grant encoding for the register-file write-back arbiter.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue claims set a bit, committed writes clear it.
module regfile_scoreboard #(
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          claim_valid,
  input  logic [regfile_pkg::REG_AW-1:0] claim_rd,
  input  logic                          commit_valid,
  input  logic [regfile_pkg::REG_AW-1:0] commit_rd,
  input  logic [regfile_pkg::REG_AW-1:0] rs1,
  input  logic [regfile_pkg::REG_AW-1:0] rs2,
  output logic                          hazard1,
  output logic                          hazard2,
  output logic [NREG-1:0]               busy,
  output logic                          err_unclaimed
);
  import regfile_pkg::*;

  localparam int SPAN = 1 << REG_AW;

  logic [SPAN-1:0] busy_full;
  logic [SPAN-1:0] busy_next;

  // Widen to the full address space so any 5-bit index is in range.
  always_comb begin
    busy_full            = '0;
    busy_full[NREG-1:0]  = busy;
    busy_next            = busy_full;
    if (commit_valid)
      busy_next[commit_rd] = 1'b0;
    if (claim_valid && (claim_rd != '0))
      busy_next[claim_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign hazard1 = busy_full[rs1];
  assign hazard2 = busy_full[rs2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy          <= '0;
      err_unclaimed <= 1'b0;
    end else begin
      busy <= busy_next[NREG-1:0];
      if (commit_valid && !busy_full[commit_rd])
        err_unclaimed <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU and load write-backs into one registered
// register-file write port, with a destination scoreboard for hazard detection.
module regfile_wb_arbiter #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [regfile_pkg::REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]                a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [regfile_pkg::REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]                b_data,
  output logic                           we3,
  output logic [regfile_pkg::REG_AW-1:0] a3,
  output logic [XLEN-1:0]                wd3,
  input  logic                           claim_valid,
  input  logic [regfile_pkg::REG_AW-1:0] claim_rd,
  input  logic [regfile_pkg::REG_AW-1:0] rs1,
  input  logic [regfile_pkg::REG_AW-1:0] rs2,
  output logic                           hazard1,
  output logic                           hazard2,
  output logic [NREG-1:0]                busy,
  output logic                           err_unclaimed
);
  import regfile_pkg::*;

  grant_e            last_grant;
  logic              a_fire;
  logic              b_fire;
  logic              xfer;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  // Each ready depends only on the other requester's valid, never its own.
  assign a_ready = !b_valid || (last_grant == GRANT_B);
  assign b_ready = !a_valid || (last_grant == GRANT_A);

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign xfer   = a_fire || b_fire;

  always_comb begin
    sel_rd   = b_rd;
    sel_data = b_data;
    if (a_fire) begin
      sel_rd   = a_rd;
      sel_data = a_data;
    end
  end

  // Output stage: one-cycle registered write port; x0 writes are swallowed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      last_grant <= GRANT_B;
    end else begin
      we3 <= xfer && (sel_rd != '0);
      if (xfer) begin
        last_grant <= a_fire ? GRANT_A : GRANT_B;
        a3         <= sel_rd;
        wd3        <= sel_data;
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk           (clk),
    .resetn        (resetn),
    .claim_valid   (claim_valid),
    .claim_rd      (claim_rd),
    .commit_valid  (we3),
    .commit_rd     (a3),
    .rs1           (rs1),
    .rs2           (rs2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .busy          (busy),
    .err_unclaimed (err_unclaimed)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter and its scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, a3, claim_rd, rs1, rs2;
  logic [31:0] a_data, b_data, wd3;
  logic        we3, claim_valid, hazard1, hazard2, err_unclaimed;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_rd          (a_rd),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_rd          (b_rd),
    .b_data        (b_data),
    .we3           (we3),
    .a3            (a3),
    .wd3           (wd3),
    .claim_valid   (claim_valid),
    .claim_rd      (claim_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .busy          (busy),
    .err_unclaimed (err_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0;
    a_data = 0; b_data = 0; claim_valid = 0; claim_rd = 0; rs1 = 0; rs2 = 0;
    step(); step();

    // Reset state, and readies follow the combinational rule during reset.
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unclaimed, 0);
    a_valid = 1; b_valid = 1; #1;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 0);
    a_valid = 0; b_valid = 0;
    resetn = 1'b1;
    step();

    // Single A write, rd 5 claimed in the same cycle.
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; claim_valid = 1; claim_rd = 5; #1;
    chk("a_ready_same_cycle", a_ready, 1);
    step();
    a_valid = 0; claim_valid = 0; #1;
    chk("wr5_we3", we3, 1);
    chk("wr5_a3", a3, 5);
    chk("wr5_wd3", wd3, 32'hDEADBEEF);
    chk("wr5_busy", busy[5], 1);
    step();
    chk("wr5_we3_drop", we3, 0);
    chk("wr5_wd3_hold", wd3, 32'hDEADBEEF);
    chk("wr5_busy_clr", busy[5], 0);
    chk("wr5_err", err_unclaimed, 0);

    // Hazard on rd 7 across claim, write and commit.
    claim_valid = 1; claim_rd = 7; rs1 = 7; rs2 = 7;
    step();
    claim_valid = 0; #1;
    chk("hz1_claimed", hazard1, 1);
    chk("hz2_claimed", hazard2, 1);
    a_valid = 1; a_rd = 7; a_data = 32'h77;
    step();
    a_valid = 0; rs2 = 0; #1;
    chk("hz_we3", we3, 1);
    chk("hz_a3", a3, 7);
    chk("hz1_during_we3", hazard1, 1);
    chk("hz2_x0", hazard2, 0);
    step();
    chk("hz1_after", hazard1, 0);
    chk("hz_busy7", busy[7], 0);

    // B write to x0: handshake only.
    b_valid = 1; b_rd = 0; b_data = 32'hFFFFFFFF; #1;
    chk("x0_b_ready", b_ready, 1);
    step();
    b_valid = 0; #1;
    chk("x0_we3", we3, 0);
    step();
    chk("x0_we3_next", we3, 0);
    chk("x0_busy", busy, 0);
    chk("x0_err", err_unclaimed, 0);

    // Claim destinations for the round-robin burst.
    claim_valid = 1; claim_rd = 1;  step();
    claim_rd = 11; step();
    claim_rd = 2;  step();
    claim_rd = 12; step();
    claim_valid = 0; #1;
    chk("rr_busy_claimed", busy, 32'h0000_1806);

    // Both valid: last grant was B, so A wins first, then alternation.
    a_valid = 1; a_rd = 1;  a_data = 32'h100;
    b_valid = 1; b_rd = 11; b_data = 32'h200; #1;
    chk("rr0_a_ready", a_ready, 1);
    chk("rr0_b_ready", b_ready, 0);
    step();
    a_rd = 2; a_data = 32'h101; #1;
    chk("rr1_we3", we3, 1);
    chk("rr1_a3", a3, 1);
    chk("rr1_wd3", wd3, 32'h100);
    chk("rr1_b_ready", b_ready, 1);
    chk("rr1_a_ready", a_ready, 0);
    step();
    b_rd = 12; b_data = 32'h201; #1;
    chk("rr2_a3", a3, 11);
    chk("rr2_wd3", wd3, 32'h200);
    chk("rr2_a_ready", a_ready, 1);
    step();
    a_rd = 3; a_data = 32'h102; #1;
    chk("rr3_a3", a3, 2);
    chk("rr3_b_ready", b_ready, 1);
    step();
    a_valid = 0; b_valid = 0; #1;
    chk("rr4_we3", we3, 1);
    chk("rr4_a3", a3, 12);
    chk("rr4_wd3", wd3, 32'h201);
    step();
    chk("rr_we3_idle", we3, 0);
    chk("rr_busy_clear", busy, 0);
    chk("rr_err", err_unclaimed, 0);

    // Claim and commit on rd 9 in the same cycle: claim wins.
    claim_valid = 1; claim_rd = 9;
    step();
    claim_valid = 0; #1;
    chk("c9_busy", busy[9], 1);
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    step();
    a_valid = 0; claim_valid = 1; claim_rd = 9; #1;
    chk("c9_we3", we3, 1);
    chk("c9_a3", a3, 9);
    step();
    claim_valid = 0; #1;
    chk("c9_busy_kept", busy[9], 1);
    chk("c9_err", err_unclaimed, 0);

    // Write to never-claimed rd 3 raises the sticky error.
    a_valid = 1; a_rd = 3; a_data = 32'h33;
    step();
    a_valid = 0; #1;
    chk("u3_we3", we3, 1);
    chk("u3_err_pre", err_unclaimed, 0);
    step();
    chk("u3_err_set", err_unclaimed, 1);
    step(); step();
    chk("u3_err_held", err_unclaimed, 1);

    // Accepted transfer, then reset before it reaches the write port.
    a_valid = 1; a_rd = 20; a_data = 32'h1234;
    step();
    a_valid = 0; resetn = 1'b0; #1;
    chk("rs_we3_async", we3, 0);
    chk("rs_busy_async", busy, 0);
    chk("rs_err_async", err_unclaimed, 0);
    chk("rs_a3_async", a3, 0);
    step();
    chk("rs_we3_in_rst", we3, 0);
    resetn = 1'b1;
    step();
    chk("rs_we3_after", we3, 0);
    chk("rs_busy_after", busy, 0);
    a_valid = 1; b_valid = 1; #1;
    chk("rs_grant_a_ready", a_ready, 1);
    chk("rs_grant_b_ready", b_ready, 0);
    a_valid = 0; b_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of the write-back port.
REQ-002 Parameter NREG, default 32: number of architectural registers; address width is 5.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 a_valid / a_ready / a_rd / a_data  in / out / in[4:0] / in[XLEN-1:0]  requester A (ALU result) write-back handshake.
REQ-006 b_valid / b_ready / b_rd / b_data  in / out / in[4:0] / in[XLEN-1:0]  requester B (load result) write-back handshake.
REQ-007 we3 / a3 / wd3  out / out[4:0] / out[XLEN-1:0]  registered register-file write port.
REQ-008 claim_valid / claim_rd  in / in[4:0]  issue stage reserves a destination register.
REQ-009 rs1 / rs2  in[4:0]  source registers queried by decode.
REQ-010 hazard1 / hazard2  out  1  source register has an outstanding write.
REQ-011 busy  out[NREG-1:0]  scoreboard vector, one bit per register.
REQ-012 err_unclaimed  out  1  sticky: a write committed to a register that was not busy.

Function
REQ-013 A transfer SHALL occur on a requester when its valid and ready are both high at a rising edge; at most one transfer SHALL occur per cycle.
REQ-014 a_ready SHALL be high when b_valid is low or last_grant = B; b_ready SHALL be high when a_valid is low or last_grant = A. Both are combinational, and no valid-to-ready path SHALL exist on the same requester.
REQ-015 last_grant SHALL update to the winning requester on every transfer (round-robin); when both are valid, the grant SHALL alternate on consecutive cycles.
REQ-016 A requester SHALL hold valid, rd and data stable until its transfer occurs.
REQ-017 The cycle after a transfer, we3 SHALL be 1 for exactly one cycle, with a3/wd3 equal to the transferred rd/data (latency 1, throughput 1 per cycle).
REQ-018 A transfer with rd = 0 SHALL complete the handshake, update last_grant and keep we3 at 0.
REQ-019 With no transfer, we3 SHALL be 0 next cycle; a3/wd3 SHALL hold their last values.
REQ-020 claim_valid with claim_rd != 0 SHALL set busy[claim_rd] at the edge; claim_rd = 0 SHALL be ignored.
REQ-021 A committed write (we3 = 1) SHALL clear busy[a3] at the end of that cycle.
REQ-022 When a claim and a commit target the same register in the same cycle, the claim SHALL win and busy stays 1.
REQ-023 busy[0] SHALL always be 0.
REQ-024 hazard1 = busy[rs1] and hazard2 = busy[rs2], both combinational. Hazard SHALL stay high during the we3 cycle and drop the following cycle.
REQ-025 A commit with we3 = 1 while busy[a3] = 0 SHALL set err_unclaimed, which stays high until reset.

Reset
REQ-026 resetn low SHALL immediately force we3 = 0, a3 = 0, wd3 = 0, busy = 0, err_unclaimed = 0 and last_grant = B, so A wins the first conflict.
REQ-027 A write pending in the output stage when reset asserts SHALL be dropped, not committed. Ready outputs SHALL follow REQ-014 during reset, but no transfer SHALL be recorded while resetn is low.

Structure
REQ-028 XLEN, register address width (5), NREG and the grant enum (GRANT_A, GRANT_B) SHALL live in shared package regfile_pkg.
REQ-029 The scoreboard (busy vector, claim/commit, hazard lookup, err_unclaimed) SHALL be sub-module regfile_scoreboard; arbitration and the output stage stay in the top.

Verification
REQ-030 Reset, then a_valid=1, a_rd=5, a_data=32'hDEADBEEF -> a_ready=1 same cycle; next cycle we3=1, a3=5, wd3=32'hDEADBEEF; the cycle after, we3=0.
REQ-031 After reset, a and b both valid for 4 cycles (rd 1..4 and 11..14) -> grants A,B,A,B, with A as the first winner; we3 stream carries rd 1, 11, 2, 12.
REQ-032 claim_rd=7, then rs1=7 -> hazard1=1; write rd=7 -> hazard1 stays 1 during the we3 cycle and is 0 one cycle later; busy[7]=0.
REQ-033 b_rd=0, b_data=32'hFFFFFFFF -> handshake completes, we3 stays 0, last_grant=B, busy unchanged, err_unclaimed=0.
REQ-034 busy[9]=1, then claim_rd=9 in the same cycle as we3 with a3=9 -> busy[9]=1; a write to never-claimed rd=3 -> err_unclaimed=1 and held.
REQ-035 Transfer accepted, then resetn pulsed low before the output cycle -> we3 never asserts; busy=0 and last_grant=B after release.
